// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 timing constants, polarity encodings and helpers
package vga_timing_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int h_total_default();
    return axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  endfunction

  function automatic int v_total_default();
    return axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
  endfunction

  // Colour bar: each index bit selects a full-scale primary, {R,G,B} = idx[2:0]
  function automatic rgb_t bar_color(input logic [2:0] idx);
    rgb_t c;
    c.red   = {8{idx[2]}};
    c.green = {8{idx[1]}};
    c.blue  = {8{idx[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - pixel-coordinate / colour interface between raster source and compositor
interface vga_timing_gen_if;
  logic [7:0]  i_red;
  logic [7:0]  i_green;
  logic [7:0]  i_blue;
  logic [15:0] o_x;
  logic [15:0] o_y;
  logic        o_h_sync;
  logic        o_v_sync;
  logic        o_de;
  logic [7:0]  o_red;
  logic [7:0]  o_green;
  logic [7:0]  o_blue;
  logic        o_frame_tick;
  logic [15:0] o_frame_count;

  modport master (
    input  i_red, i_green, i_blue,
    output o_x, o_y, o_h_sync, o_v_sync, o_de,
    output o_red, o_green, o_blue, o_frame_tick, o_frame_count
  );

  modport slave (
    output i_red, i_green, i_blue,
    input  o_x, o_y, o_h_sync, o_v_sync, o_de,
    input  o_red, o_green, o_blue, o_frame_tick, o_frame_count
  );
endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter with wrap, active and sync decode
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter bit POL    = SYNC_ACTIVE_LOW
) (
  input  logic        clk,
  input  logic        enable,
  input  logic        clear,
  output logic [15:0] count,
  output logic        wrap,
  output logic        active,
  output logic        sync_level
);

  localparam logic [15:0] LAST       = 16'(axis_total(ACTIVE, FP, SYNC, BP) - 1);
  localparam logic [15:0] ACT_END    = 16'(ACTIVE);
  localparam logic [15:0] SYNC_START = 16'(ACTIVE + FP);
  localparam logic [15:0] SYNC_END   = 16'(ACTIVE + FP + SYNC);

  logic [15:0] count_q, count_d;

  // Next position: clear dominates, otherwise step on enable and fold back after the last slot
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == LAST) ? '0 : count_q + 16'd1;
    end
  end

  // Position register; clear is the synchronous reset path
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  // Decodes are taken from the current (pre-increment) position
  assign count      = count_q;
  assign wrap       = enable && (count_q == LAST);
  assign active     = (count_q < ACT_END);
  assign sync_level = (count_q >= SYNC_START && count_q < SYNC_END) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing source with aligned blanked RGB output; VGA_TEST_PATTERN_EN selects colour bars
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = SYNC_ACTIVE_LOW
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  vga_timing_gen_if.master  vif
);

  localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  logic [15:0] h_count, v_count;
  logic        h_wrap, v_wrap;
  logic        h_active, v_active;
  logic        h_sync_lvl, v_sync_lvl;

  logic        de_q, de_d;
  logic        h_sync_q, h_sync_d;
  logic        v_sync_q, v_sync_d;
  rgb_t        rgb_q, rgb_d;
  logic        frame_tick_q, frame_tick_d;
  logic [15:0] frame_count_q, frame_count_d;
  rgb_t        pix;

  assign tick = (div_q == DIV_LAST);

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (SYNC_POL)
  ) u_h_axis (
    .clk        (i_clk),
    .enable     (tick),
    .clear      (~i_rst_n),
    .count      (h_count),
    .wrap       (h_wrap),
    .active     (h_active),
    .sync_level (h_sync_lvl)
  );

  // The vertical axis only steps on the horizontal wrap, so v_wrap marks the last pixel of the frame
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (SYNC_POL)
  ) u_v_axis (
    .clk        (i_clk),
    .enable     (h_wrap),
    .clear      (~i_rst_n),
    .count      (v_count),
    .wrap       (v_wrap),
    .active     (v_active),
    .sync_level (v_sync_lvl)
  );

`ifdef VGA_TEST_PATTERN_EN
  localparam int          BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam logic [15:0] BAR_W16 = 16'(BAR_W);
  logic [15:0] bar_idx;

  // Compositor input is ignored; the bar index comes straight from the horizontal position
  always_comb begin
    bar_idx = h_count / BAR_W16;
    pix     = bar_color(bar_idx[2:0]);
  end
`else
  // Compositor colour for the current coordinate
  always_comb begin
    pix.red   = vif.i_red;
    pix.green = vif.i_green;
    pix.blue  = vif.i_blue;
  end
`endif

  // Divider and output stage: capture decodes of the pre-increment position on each pixel tick
  always_comb begin
    div_d         = div_q;
    de_d          = de_q;
    h_sync_d      = h_sync_q;
    v_sync_d      = v_sync_q;
    rgb_d         = rgb_q;
    frame_tick_d  = 1'b0;
    frame_count_d = frame_count_q;
    if (!i_rst_n) begin
      div_d         = '0;
      de_d          = 1'b0;
      h_sync_d      = ~SYNC_POL;
      v_sync_d      = ~SYNC_POL;
      rgb_d         = '0;
      frame_count_d = '0;
    end else begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        de_d     = h_active && v_active;
        h_sync_d = h_sync_lvl;
        v_sync_d = v_sync_lvl;
        rgb_d    = (h_active && v_active) ? pix : '0;
        if (v_wrap) begin
          frame_tick_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
    end
  end

  // Output and divider registers
  always_ff @(posedge i_clk) begin
    div_q         <= div_d;
    de_q          <= de_d;
    h_sync_q      <= h_sync_d;
    v_sync_q      <= v_sync_d;
    rgb_q         <= rgb_d;
    frame_tick_q  <= frame_tick_d;
    frame_count_q <= frame_count_d;
  end

  assign vif.o_x           = h_count;
  assign vif.o_y           = v_count;
  assign vif.o_h_sync      = h_sync_q;
  assign vif.o_v_sync      = v_sync_q;
  assign vif.o_de          = de_q;
  assign vif.o_red         = rgb_q.red;
  assign vif.o_green       = rgb_q.green;
  assign vif.o_blue        = rgb_q.blue;
  assign vif.o_frame_tick  = frame_tick_q;
  assign vif.o_frame_count = frame_count_q;

endmodule
